instruction_fetch: RTL and testbench

Fetch sequencer for the 8-bit CPU. It owns the program counter, reads instruction bytes from program memory over a request/valid handshake, and presents the opcode (plus an optional immediate byte) to the instruction decoder. It sits between program memory and the control unit, feeding the `inst` bus the decoder consumes.

---
 rtl/instruction_fetch_pkg.sv | 20 ++
 rtl/instruction_fetch_program_counter.sv | 38 +++
 rtl/instruction_fetch.sv | 126 ++++++++++++
 tb/tb_instruction_fetch.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared CPU definitions: fetch sequencer states and opcode classes.
package instruction_fetch_pkg;

  typedef enum logic [2:0] {
    REQ_OP   = 3'd0,
    WAIT_OP  = 3'd1,
    REQ_IMM  = 3'd2,
    WAIT_IMM = 3'd3,
    ISSUE    = 3'd4
  } fetch_state_e;

  // Opcodes whose top three bits match this class carry an immediate byte.
  localparam logic [2:0] OPC_CLASS_TWO_BYTE = 3'b111;
  localparam logic [7:0] INST_NOP           = 8'h00;

  function automatic logic is_two_byte(input logic [7:0] op);
    return (op[7:5] == OPC_CLASS_TWO_BYTE);
  endfunction

endpackage

// File: rtl/instruction_fetch_program_counter.sv
// Program counter: load (jump), increment with natural wrap, async reset.
module program_counter #(
  parameter int unsigned            ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] load_addr_i,
  input  logic                  inc_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] pc_inc_o
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;

  assign pc_inc_o = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  assign pc_o     = pc_q;

  // Next PC: a jump load takes priority over the sequential increment.
  always_comb begin
    pc_d = pc_q;
    if (load_i)
      pc_d = load_addr_i;
    else if (inc_i)
      pc_d = pc_inc_o;
  end

  // PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc_q <= RESET_PC;
    else
      pc_q <= pc_d;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch sequencer: walks program memory through a request/valid handshake and
// hands opcode (+ optional immediate) to the decoder.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned            ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  memRdEn,
  input  logic [7:0]            memData,
  input  logic                  memValid,
  output logic [7:0]            inst,
  output logic [7:0]            imm,
  output logic                  instValid,
  input  logic                  instAck,
  input  logic                  jmpEn,
  input  logic [ADDR_WIDTH-1:0] jmpAddr,
  output logic [ADDR_WIDTH-1:0] pc
);

  fetch_state_e          state_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  mem_rd_en_q;
  logic [7:0]            inst_q;
  logic [7:0]            imm_q;
  logic                  inst_valid_q;

  logic                  pc_inc_en;
  logic                  pc_load_en;
  logic [ADDR_WIDTH-1:0] pc_cur;
  logic [ADDR_WIDTH-1:0] pc_plus1;

  // PC moves on each accepted byte, or jumps when the decoder acks a redirect.
  always_comb begin
    pc_inc_en  = memValid && ((state_q == WAIT_OP) || (state_q == WAIT_IMM));
    pc_load_en = (state_q == ISSUE) && instAck && jmpEn;
  end

  program_counter #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_PC   (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst         (rst),
    .load_i      (pc_load_en),
    .load_addr_i (jmpAddr),
    .inc_i       (pc_inc_en),
    .pc_o        (pc_cur),
    .pc_inc_o    (pc_plus1)
  );

  // Fetch FSM. The read request is registered one edge ahead so memRdEn is
  // high during the REQ_* cycle itself; out of reset REQ_OP spends one extra
  // cycle arming the request because memRdEn must reset low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= REQ_OP;
      mem_addr_q   <= RESET_PC;
      mem_rd_en_q  <= 1'b0;
      inst_q       <= INST_NOP;
      imm_q        <= INST_NOP;
      inst_valid_q <= 1'b0;
    end else begin
      case (state_q)
        REQ_OP: begin
          if (!mem_rd_en_q) begin
            mem_rd_en_q <= 1'b1;
            mem_addr_q  <= pc_cur;
          end else begin
            mem_rd_en_q <= 1'b0;
            state_q     <= WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (memValid) begin
            inst_q <= memData;
            if (is_two_byte(memData)) begin
              mem_rd_en_q <= 1'b1;
              mem_addr_q  <= pc_plus1;
              state_q     <= REQ_IMM;
            end else begin
              imm_q        <= INST_NOP;
              inst_valid_q <= 1'b1;
              state_q      <= ISSUE;
            end
          end
        end
        REQ_IMM: begin
          mem_rd_en_q <= 1'b0;
          state_q     <= WAIT_IMM;
        end
        WAIT_IMM: begin
          if (memValid) begin
            imm_q        <= memData;
            inst_valid_q <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          if (instAck) begin
            inst_valid_q <= 1'b0;
            mem_rd_en_q  <= 1'b1;
            mem_addr_q   <= jmpEn ? jmpAddr : pc_cur;
            state_q      <= REQ_OP;
          end
        end
        default: begin
          mem_rd_en_q  <= 1'b0;
          inst_valid_q <= 1'b0;
          state_q      <= REQ_OP;
        end
      endcase
    end
  end

  assign memAddr   = mem_addr_q;
  assign memRdEn   = mem_rd_en_q;
  assign inst      = inst_q;
  assign imm       = imm_q;
  assign instValid = inst_valid_q;
  assign pc        = pc_cur;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a RESET_PC=0 instance driven through
// one-byte, two-byte, stall/jump, latency and mid-read reset cases, and a
// RESET_PC=8'hFF instance exercising the wrapped immediate fetch.
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       rst;

  // Instance A (RESET_PC = 0)
  logic [7:0] memAddr_a, memData_a, inst_a, imm_a, pc_a, jmpAddr_a;
  logic       memRdEn_a, memValid_a, instValid_a, instAck_a, jmpEn_a;
  logic       resp_valid_a, force_valid;
  logic [7:0] resp_data_a, force_data;
  logic [7:0] mem_a [256];
  int unsigned lat_a;

  // Instance B (RESET_PC = 8'hFF)
  logic [7:0] memAddr_b, memData_b, inst_b, imm_b, pc_b;
  logic       memRdEn_b, memValid_b, instValid_b;
  logic       instAck_b = 1'b1;
  logic       jmpEn_b   = 1'b0;
  logic [7:0] jmpAddr_b = 8'h00;
  logic [7:0] mem_b [256];
  logic       b_done = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  assign memValid_a = resp_valid_a | force_valid;
  assign memData_a  = force_valid ? force_data : resp_data_a;

  instruction_fetch #(.ADDR_WIDTH(8), .RESET_PC(8'h00)) dut_a (
    .clk(clk), .rst(rst), .memAddr(memAddr_a), .memRdEn(memRdEn_a),
    .memData(memData_a), .memValid(memValid_a), .inst(inst_a), .imm(imm_a),
    .instValid(instValid_a), .instAck(instAck_a), .jmpEn(jmpEn_a),
    .jmpAddr(jmpAddr_a), .pc(pc_a)
  );

  instruction_fetch #(.ADDR_WIDTH(8), .RESET_PC(8'hFF)) dut_b (
    .clk(clk), .rst(rst), .memAddr(memAddr_b), .memRdEn(memRdEn_b),
    .memData(memData_b), .memValid(memValid_b), .inst(inst_b), .imm(imm_b),
    .instValid(instValid_b), .instAck(instAck_b), .jmpEn(jmpEn_b),
    .jmpAddr(jmpAddr_b), .pc(pc_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Memory model A: answers a request seen on a falling edge 1+lat_a cycles later.
  initial begin : resp_a
    int unsigned pend;
    logic [7:0]  paddr;
    pend = 0; paddr = '0;
    resp_valid_a = 1'b0; resp_data_a = '0;
    forever begin
      @(negedge clk);
      resp_valid_a = 1'b0;
      if (rst) pend = 0;
      else begin
        if (pend != 0) begin
          pend--;
          if (pend == 0) begin
            resp_valid_a = 1'b1;
            resp_data_a  = mem_a[paddr];
          end
        end
        if (memRdEn_a) begin
          pend  = 1 + lat_a;
          paddr = memAddr_a;
        end
      end
    end
  end

  // Memory model B: single-cycle response.
  initial begin : resp_b
    logic       pend;
    logic [7:0] paddr;
    pend = 1'b0; paddr = '0;
    memValid_b = 1'b0; memData_b = '0;
    forever begin
      @(negedge clk);
      memValid_b = 1'b0;
      if (rst) pend = 1'b0;
      else begin
        if (pend) begin
          memValid_b = 1'b1;
          memData_b  = mem_b[paddr];
          pend       = 1'b0;
        end
        if (memRdEn_b) begin
          pend  = 1'b1;
          paddr = memAddr_b;
        end
      end
    end
  end

  // Instance B: opcode at 8'hFF, immediate must come from 8'h00.
  initial begin : chk_b
    logic [7:0]  req [2];
    int unsigned nreq, idx;
    logic        seen;
    nreq = 0; idx = 0; seen = 1'b0;
    req[0] = '0; req[1] = '0;
    @(negedge rst);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (memRdEn_b && nreq < 2) begin
        req[nreq] = memAddr_b;
        nreq++;
      end
      if (instValid_b) begin
        seen = 1'b1;
        idx  = i;
        break;
      end
    end
    check("b_issue_seen",  seen,   1'b1);
    check("b_issue_cycle", idx,    4);
    check("b_req_count",   nreq,   2);
    check("b_req_op_addr", req[0], 8'hFF);
    check("b_req_imm_wrap", req[1], 8'h00);
    check("b_inst",        inst_b, 8'hE7);
    check("b_imm",         imm_b,  8'h33);
    check("b_pc_wrapped",  pc_b,   8'h01);
    b_done = 1'b1;
  end

  initial begin : main
    int unsigned cnt;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 8'h00;
      mem_b[i] = 8'h00;
    end
    mem_a[8'h00] = 8'h0B;  // one-byte
    mem_a[8'h01] = 8'hE0;  // two-byte opcode
    mem_a[8'h02] = 8'h5A;  // its immediate
    mem_a[8'h03] = 8'h21;  // one-byte, stalled by decoder
    mem_a[8'h40] = 8'hE5;  // jump target, two-byte
    mem_a[8'h41] = 8'h77;
    mem_b[8'hFF] = 8'hE7;
    mem_b[8'h00] = 8'h33;

    rst = 1'b1;
    force_valid = 1'b1; force_data = 8'hFF;
    instAck_a = 1'b1; jmpEn_a = 1'b1; jmpAddr_a = 8'h99;
    lat_a = 0;

    // Reset with memValid and ack/jump active: all reset values hold.
    repeat (3) @(negedge clk);
    check("rst_inst",      inst_a,      8'h00);
    check("rst_imm",       imm_a,       8'h00);
    check("rst_instValid", instValid_a, 1'b0);
    check("rst_memRdEn",   memRdEn_a,   1'b0);
    check("rst_memAddr",   memAddr_a,   8'h00);
    check("rst_pc",        pc_a,        8'h00);
    check("rst_pc_b",      pc_b,        8'hFF);
    check("rst_memAddr_b", memAddr_b,   8'hFF);

    rst = 1'b0; force_valid = 1'b0; jmpEn_a = 1'b0; jmpAddr_a = 8'h00;
    cnt = 99;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (memRdEn_a) begin cnt = i; break; end
    end
    check("first_req_cycle", cnt,       0);
    check("first_req_addr",  memAddr_a, 8'h00);

    // One-byte 8'h0B, immediate ack (request was cycle 0).
    @(negedge clk);
    check("ob_wait_novalid", instValid_a, 1'b0);
    @(negedge clk);
    check("ob_valid", instValid_a, 1'b1);
    check("ob_inst",  inst_a,      8'h0B);
    check("ob_imm",   imm_a,       8'h00);
    check("ob_pc",    pc_a,        8'h01);
    @(negedge clk);
    check("ob_valid_1cyc", instValid_a, 1'b0);
    check("ob_next_req",   memRdEn_a,   1'b1);
    check("ob_next_addr",  memAddr_a,   8'h01);

    // Two-byte 8'hE0 8'h5A fetched from 8'h01/8'h02, so pc ends at 8'h03.
    @(negedge clk);
    @(negedge clk);
    check("tb_imm_req",   memRdEn_a,   1'b1);
    check("tb_imm_addr",  memAddr_a,   8'h02);
    check("tb_inst_early", inst_a,     8'hE0);
    check("tb_novalid",   instValid_a, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("tb_valid", instValid_a, 1'b1);
    check("tb_inst",  inst_a,      8'hE0);
    check("tb_imm",   imm_a,       8'h5A);
    check("tb_pc",    pc_a,        8'h03);
    @(negedge clk);
    check("tb_next_addr", memAddr_a, 8'h03);
    instAck_a = 1'b0;

    // Decoder stalls 5 cycles: instruction held, no request issued.
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_hold", {instValid_a, memRdEn_a, inst_a}, {1'b1, 1'b0, 8'h21});
    end
    instAck_a = 1'b1; jmpEn_a = 1'b1; jmpAddr_a = 8'h40;
    lat_a = 2;
    @(negedge clk);
    check("jmp_req",     memRdEn_a,   1'b1);
    check("jmp_addr",    memAddr_a,   8'h40);
    check("jmp_pc",      pc_a,        8'h40);
    check("jmp_novalid", instValid_a, 1'b0);
    instAck_a = 1'b0; jmpEn_a = 1'b0; jmpAddr_a = 8'h00;

    // Memory latency +2 stretches the opcode wait by 2 cycles.
    cnt = 99;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (memRdEn_a) begin cnt = i; break; end
    end
    check("lat_imm_req_cycle", cnt,       3);
    check("lat_imm_addr",      memAddr_a, 8'h41);
    check("lat_inst",          inst_a,    8'hE5);

    // Reset in WAIT_IMM; a stale response straddles the release.
    @(negedge clk);
    check("wimm_norden", memRdEn_a, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_pc",      pc_a,        8'h00);
    check("midrst_addr",    memAddr_a,   8'h00);
    check("midrst_inst",    inst_a,      8'h00);
    check("midrst_novalid", instValid_a, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0; lat_a = 0; instAck_a = 1'b1;
    force_valid = 1'b1; force_data = 8'hFF;
    @(negedge clk);
    check("restart_req",  memRdEn_a,   1'b1);
    check("restart_addr", memAddr_a,   8'h00);
    check("stale_novalid", instValid_a, 1'b0);
    @(negedge clk);
    force_valid = 1'b0;
    check("stale_dropped", instValid_a, 1'b0);
    @(negedge clk);
    check("restart_valid", instValid_a, 1'b1);
    check("restart_inst",  inst_a,      8'h0B);

    cnt = 0;
    while (!b_done && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    check("b_done", b_done, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
